// File: rtl/bnn_pkg.sv
// Network geometry shared by the parameter loader and BNN_network: region sizes,
// the region selector enum and the per-region byte count.
package bnn_pkg;

  localparam int IMG_SIZE    = 30;
  localparam int KERNEL_SIZE = 3;
  localparam int BNN1_CHANL  = 8;
  localparam int BNN2_CHANL  = 16;
  localparam int MLP_CHANL   = 16;
  localparam int NUM_CLASS   = 10;

  localparam int BNN2_IMG_SIZE = ((IMG_SIZE - 2) / 2 - 2) / 2;

  localparam int L0 = IMG_SIZE * IMG_SIZE;
  localparam int L1 = KERNEL_SIZE * KERNEL_SIZE * BNN1_CHANL;
  localparam int L2 = KERNEL_SIZE * KERNEL_SIZE * BNN1_CHANL * BNN2_CHANL;
  localparam int L3 = BNN2_CHANL * BNN2_IMG_SIZE * BNN2_IMG_SIZE * MLP_CHANL;
  localparam int L4 = MLP_CHANL * NUM_CLASS;

  localparam int B0 = (L0 + 7) / 8;
  localparam int B1 = (L1 + 7) / 8;
  localparam int B2 = (L2 + 7) / 8;
  localparam int B3 = (L3 + 7) / 8;
  localparam int B4 = (L4 + 7) / 8;

  localparam int NUM_REGIONS = 5;
  // Region 3 is by far the largest, so it sets the counter width.
  localparam int CNT_W = $clog2(B3);

  typedef enum logic [2:0] {
    R_IMG = 3'd0,
    R_W1  = 3'd1,
    R_W2  = 3'd2,
    R_M1  = 3'd3,
    R_M2  = 3'd4
  } region_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] region_bytes(input region_e r);
    case (r)
      R_IMG:   return CNT_W'(B0);
      R_W1:    return CNT_W'(B1);
      R_W2:    return CNT_W'(B2);
      R_M1:    return CNT_W'(B3);
      R_M2:    return CNT_W'(B4);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Byte stream from the chip pins into the parameter loader (valid/ready).
interface bnn_param_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bnn_param_loader.sv
// Command-framed byte loader: a command byte selects a region, the following
// payload bytes fill it LSB first, and net_start fires once every region is valid.
module bnn_param_loader
  import bnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  bnn_param_loader_if.slave      bus,
  input  logic                   net_busy,
  input  logic                   err_clr,
  output logic [L0-1:0]          in_image,
  output logic [L1-1:0]          bnn1_weights,
  output logic [L2-1:0]          bnn2_weights,
  output logic [L3-1:0]          mlp1_weights,
  output logic [L4-1:0]          mlp2_weights,
  output logic [NUM_REGIONS-1:0] loaded,
  output logic                   net_start,
  output logic                   err
);

  localparam int IW0 = $clog2(L0);
  localparam int IW1 = $clog2(L1);
  localparam int IW2 = $clog2(L2);
  localparam int IW3 = $clog2(L3);
  localparam int IW4 = $clog2(L4);

  // Bit offset of each region's final byte; only the image has a partial tail.
  localparam int T0 = 8 * (B0 - 1);
  localparam int T1 = 8 * (B1 - 1);
  localparam int T2 = 8 * (B2 - 1);
  localparam int T3 = 8 * (B3 - 1);
  localparam int T4 = 8 * (B4 - 1);

  state_e                 state_q, state_d;
  region_e                region_q, region_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] loaded_q, loaded_d;
  logic                   err_q, err_d;
  logic                   start_q, start_d;

  logic [L0-1:0] img_q;
  logic [L1-1:0] w1_q;
  logic [L2-1:0] w2_q;
  logic [L3-1:0] m1_q;
  logic [L4-1:0] m2_q;

  logic             accept;
  logic             cmd_ok;
  logic             wr_en;
  logic             last_byte;
  logic [CNT_W+2:0] byte_off;

  assign bus.in_ready = ~net_busy;
  assign accept       = bus.in_valid && !net_busy;
  assign cmd_ok       = (bus.in_data[7:3] == 5'd0) && (bus.in_data[2:0] < 3'(NUM_REGIONS));
  assign byte_off     = {cnt_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    err_d     = err_q && !err_clr;
    start_d   = 1'b0;
    wr_en     = 1'b0;
    last_byte = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_ok) begin
            region_d                    = region_e'(bus.in_data[2:0]);
            loaded_d[bus.in_data[2:0]]  = 1'b0;
            cnt_d                       = '0;
            state_d                     = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt_q == region_bytes(region_q) - CNT_W'(1)) begin
            last_byte          = 1'b1;
            loaded_d[region_q] = 1'b1;
            start_d            = &loaded_d;
            state_d            = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      region_q <= R_IMG;
      cnt_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  // The last byte writes a constant-width tail so padding never leaves the region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_q <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      m1_q  <= '0;
      m2_q  <= '0;
    end else if (wr_en) begin
      case (region_q)
        R_IMG: if (last_byte) img_q[L0-1:T0] <= bus.in_data[L0-T0-1:0];
               else           img_q[IW0'(byte_off) +: 8] <= bus.in_data;
        R_W1:  if (last_byte) w1_q[L1-1:T1] <= bus.in_data[L1-T1-1:0];
               else           w1_q[IW1'(byte_off) +: 8] <= bus.in_data;
        R_W2:  if (last_byte) w2_q[L2-1:T2] <= bus.in_data[L2-T2-1:0];
               else           w2_q[IW2'(byte_off) +: 8] <= bus.in_data;
        R_M1:  if (last_byte) m1_q[L3-1:T3] <= bus.in_data[L3-T3-1:0];
               else           m1_q[IW3'(byte_off) +: 8] <= bus.in_data;
        R_M2:  if (last_byte) m2_q[L4-1:T4] <= bus.in_data[L4-T4-1:0];
               else           m2_q[IW4'(byte_off) +: 8] <= bus.in_data;
        default: ;
      endcase
    end
  end

  assign in_image     = img_q;
  assign bnn1_weights = w1_q;
  assign bnn2_weights = w2_q;
  assign mlp1_weights = m1_q;
  assign mlp2_weights = m2_q;
  assign loaded       = loaded_q;
  assign net_start    = start_q;
  assign err          = err_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: drives command-framed byte streams and checks against
// a bit-level model of the five regions, flags, error and start pulse.
module tb_bnn_param_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic net_busy = 1'b0;
  logic err_clr = 1'b0;
  always #5 clk = ~clk;

  bnn_param_loader_if bus();

  logic [899:0]  in_image;
  logic [71:0]   bnn1_weights;
  logic [1151:0] bnn2_weights;
  logic [9215:0] mlp1_weights;
  logic [159:0]  mlp2_weights;
  logic [4:0]    loaded;
  logic          net_start;
  logic          err;

  bnn_param_loader dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .net_busy     (net_busy),
    .err_clr      (err_clr),
    .in_image     (in_image),
    .bnn1_weights (bnn1_weights),
    .bnn2_weights (bnn2_weights),
    .mlp1_weights (mlp1_weights),
    .mlp2_weights (mlp2_weights),
    .loaded       (loaded),
    .net_start    (net_start),
    .err          (err)
  );

  int errors = 0;
  int checks = 0;

  int len_r [5] = '{900, 72, 1152, 9216, 160};

  logic [9215:0] m_reg [5];
  logic [4:0]    m_loaded;
  logic          m_err;
  logic          m_start;
  bit            m_inload;
  int            m_r;
  int            m_k;

  function automatic int nbytes(input int r);
    return (len_r[r] + 7) / 8;
  endfunction

  function automatic logic [9215:0] dut_reg(input int r);
    logic [9215:0] v;
    v = '0;
    case (r)
      0: v[899:0]  = in_image;
      1: v[71:0]   = bnn1_weights;
      2: v[1151:0] = bnn2_weights;
      3: v         = mlp1_weights;
      default: v[159:0] = mlp2_weights;
    endcase
    return v;
  endfunction

  function automatic int first_diff(input int r);
    logic [9215:0] a;
    a = dut_reg(r);
    if (a === m_reg[r]) return -1;
    for (int i = 0; i < 9216; i++)
      if (a[i] !== m_reg[r][i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 5; r++) m_reg[r] = '0;
    m_loaded = '0;
    m_err    = 1'b0;
    m_start  = 1'b0;
    m_inload = 1'b0;
    m_r      = 0;
    m_k      = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (!m_inload) begin
      if (b[7:3] == 5'd0 && b[2:0] < 3'd5) begin
        m_r = int'(b[2:0]);
        m_loaded[m_r] = 1'b0;
        m_k = 0;
        m_inload = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      for (int j = 0; j < 8; j++)
        if (8 * m_k + j < len_r[m_r]) m_reg[m_r][8 * m_k + j] = b[j];
      m_k++;
      if (m_k == nbytes(m_r)) begin
        m_inload = 1'b0;
        m_loaded[m_r] = 1'b1;
        m_start = &m_loaded;
      end
    end
  endtask

  // Present one byte (or an idle cycle) across a clock edge and update the model.
  task automatic step(input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    m_start = 1'b0;
    if (err_clr) m_err = 1'b0;
    if (v && !net_busy) model_accept(d);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (loaded !== 5'b00000) begin errors++; $display("FAIL reset_loaded: got %b want 00000", loaded); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (net_start !== 1'b0) begin errors++; $display("FAIL reset_net_start: got %b want 0", net_start); end
    for (int r = 0; r < 5; r++) begin
      int d;
      d = first_diff(r);
      checks++; if (d >= 0) begin errors++; $display("FAIL reset_region%0d: bit %0d got %b want %b", r, d, dut_reg(r)[d], m_reg[r][d]); end
    end
    $display("test_reset: done");
  endtask

  task automatic test_w1_load();
    int d;
    step(1'b1, 8'h01);
    checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL w1_cmd_loaded: got %b want %b", loaded, m_loaded); end
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 8'(k));
      checks++; if (net_start !== 1'b0) begin errors++; $display("FAIL w1_no_start: byte %0d got %b want 0", k, net_start); end
      checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL w1_loaded: byte %0d got %b want %b", k, loaded, m_loaded); end
    end
    checks++; if (loaded !== 5'b00010) begin errors++; $display("FAIL w1_loaded_final: got %b want 00010", loaded); end
    checks++; if (bnn1_weights[7:0] !== 8'h01) begin errors++; $display("FAIL w1_low_byte: got %h want 01", bnn1_weights[7:0]); end
    checks++; if (bnn1_weights[71:64] !== 8'h09) begin errors++; $display("FAIL w1_high_byte: got %h want 09", bnn1_weights[71:64]); end
    d = first_diff(1);
    checks++; if (d >= 0) begin errors++; $display("FAIL w1_region: bit %0d got %b want %b", d, dut_reg(1)[d], m_reg[1][d]); end
    step(1'b0, 8'h00);
    $display("test_w1_load: loaded=%b", loaded);
  endtask

  task automatic test_image_ones();
    logic [899:0] ones;
    int d;
    ones = '1;
    step(1'b1, 8'h00);
    for (int k = 0; k < 113; k++) step(1'b1, 8'hFF);
    checks++; if (in_image !== ones) begin errors++; $display("FAIL img_all_ones: first zero bit %0d", first_diff(0)); end
    d = first_diff(0);
    checks++; if (d >= 0) begin errors++; $display("FAIL img_region: bit %0d got %b want %b", d, dut_reg(0)[d], m_reg[0][d]); end
    checks++; if (loaded !== 5'b00011) begin errors++; $display("FAIL img_loaded: got %b want 00011", loaded); end
    checks++; if (net_start !== 1'b0) begin errors++; $display("FAIL img_no_start: got %b want 0", net_start); end
    step(1'b0, 8'h00);
    $display("test_image_ones: loaded=%b", loaded);
  endtask

  task automatic test_start();
    int pulses;
    for (int r = 2; r <= 4; r++) begin
      step(1'b1, 8'(r));
      for (int k = 0; k < nbytes(r); k++) begin
        step(1'b1, 8'($urandom));
        checks++; if (net_start !== m_start) begin errors++; $display("FAIL start_pre r%0d byte %0d: got %b want %b", r, k, net_start, m_start); end
      end
    end
    step(1'b1, 8'h00);
    checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL start_img_cmd_loaded: got %b want %b", loaded, m_loaded); end
    pulses = 0;
    for (int k = 0; k < 113; k++) begin
      if (k == 50) begin
        net_busy = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_busy_ready: got %b want 0", bus.in_ready); end
        for (int s = 0; s < 3; s++) begin
          step(1'b1, 8'($urandom));
          checks++; if (loaded !== m_loaded || net_start !== 1'b0) begin errors++; $display("FAIL start_busy_hold: loaded %b start %b want %b 0", loaded, net_start, m_loaded); end
        end
        net_busy = 1'b0;
      end
      step(1'b1, 8'($urandom));
      if (net_start === 1'b1) pulses++;
      checks++; if (net_start !== m_start) begin errors++; $display("FAIL start_pulse: byte %0d got %b want %b", k, net_start, m_start); end
    end
    checks++; if (net_start !== 1'b1 || pulses != 1) begin errors++; $display("FAIL start_single: got start %b pulses %0d want 1 and 1", net_start, pulses); end
    step(1'b0, 8'h00);
    checks++; if (net_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0", net_start); end
    for (int r = 0; r < 5; r++) begin
      int d;
      d = first_diff(r);
      checks++; if (d >= 0) begin errors++; $display("FAIL start_region%0d: bit %0d got %b want %b", r, d, dut_reg(r)[d], m_reg[r][d]); end
    end
    $display("test_start: pulses=%0d loaded=%b", pulses, loaded);
  endtask

  task automatic test_errors();
    int d;
    step(1'b1, 8'h05);
    checks++; if (err !== 1'b1 || loaded !== m_loaded) begin errors++; $display("FAIL err_bad_region: err %b loaded %b want 1 %b", err, loaded, m_loaded); end
    step(1'b1, 8'h21);
    checks++; if (err !== 1'b1 || loaded !== m_loaded) begin errors++; $display("FAIL err_high_bits: err %b loaded %b want 1 %b", err, loaded, m_loaded); end
    step(1'b1, 8'h04);
    checks++; if (loaded !== m_loaded) begin errors++; $display("FAIL err_then_cmd: loaded %b want %b", loaded, m_loaded); end
    for (int k = 0; k < 20; k++) step(1'b1, 8'($urandom));
    d = first_diff(4);
    checks++; if (d >= 0 || loaded !== m_loaded) begin errors++; $display("FAIL err_r4_load: bit %0d loaded %b want %b", d, loaded, m_loaded); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
    err_clr = 1'b1;
    step(1'b1, 8'hFF);
    err_clr = 1'b0;
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_set_wins: got %b want %b", err, m_err); end
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    err_clr = 1'b0;
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_clear2: got %b want %b", err, m_err); end
    $display("test_errors: err=%b loaded=%b", err, loaded);
  endtask

  task automatic test_reset_midload();
    int d;
    step(1'b1, 8'h02);
    for (int k = 0; k < 50; k++) step(1'b1, 8'($urandom));
    #2 rst = 1'b1;
    model_reset();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (loaded !== 5'b00000 || err !== 1'b0 || net_start !== 1'b0) begin errors++; $display("FAIL rst_flags: loaded %b err %b start %b want 0", loaded, err, net_start); end
    for (int r = 0; r < 5; r++) begin
      d = first_diff(r);
      checks++; if (d >= 0) begin errors++; $display("FAIL rst_region%0d: bit %0d nonzero", r, d); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h02);
    for (int k = 0; k < 144; k++) step(1'b1, 8'($urandom));
    checks++; if (loaded !== 5'b00100) begin errors++; $display("FAIL rst_reload_loaded: got %b want 00100", loaded); end
    d = first_diff(2);
    checks++; if (d >= 0) begin errors++; $display("FAIL rst_reload_region: bit %0d got %b want %b", d, dut_reg(2)[d], m_reg[2][d]); end
    step(1'b0, 8'h00);
    $display("test_reset_midload: loaded=%b", loaded);
  endtask

  task automatic test_back_to_back();
    int cyc;
    cyc = 0;
    for (int t = 0; t < 30; t++) begin
      logic [7:0] cmd;
      int r;
      r = ($urandom_range(0, 1) == 0) ? 1 : 4;
      cmd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(r);
      step(1'b1, cmd);
      while (m_inload) begin
        net_busy = ($urandom_range(0, 4) == 0);
        err_clr  = ($urandom_range(0, 7) == 0);
        step($urandom_range(0, 3) != 0, 8'($urandom));
        cyc++;
        checks++; if ({loaded, err, net_start} !== {m_loaded, m_err, m_start}) begin errors++; $display("FAIL b2b_flags: cyc %0d got %b %b %b want %b %b %b", cyc, loaded, err, net_start, m_loaded, m_err, m_start); end
        if (cyc > 5000) begin
          errors++;
          $display("FAIL b2b_timeout: load did not finish within cycle budget");
          m_inload = 1'b0;
        end
      end
      net_busy = 1'b0;
      err_clr  = 1'b0;
    end
    step(1'b0, 8'h00);
    for (int r = 0; r < 5; r++) begin
      int d;
      d = first_diff(r);
      checks++; if (d >= 0) begin errors++; $display("FAIL b2b_region%0d: bit %0d got %b want %b", r, d, dut_reg(r)[d], m_reg[r][d]); end
    end
    $display("test_back_to_back: cycles=%0d loaded=%b", cyc, loaded);
  endtask

  initial begin
    test_reset();
    test_w1_load();
    test_image_ones();
    test_start();
    test_errors();
    test_reset_midload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
